// File: rtl/sdram_cmd_decode.sv
// UART byte-stream command parser feeding the SDRAM write FIFO and read/write triggers.
// Optional statistics counters are enabled with CMD_DECODE_STAT_EN.
module sdram_cmd_decode #(
    parameter logic [7:0]  WR_CMD      = 8'h55,
    parameter logic [7:0]  RD_CMD      = 8'hAA,
    parameter int unsigned WR_LEN      = 4,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic        wfifo_wr_en,
    output logic [7:0]  wfifo_data,
    output logic        wr_trig,
    output logic        rd_trig,
`ifdef CMD_DECODE_STAT_EN
    output logic [15:0] wr_cmd_cnt,
    output logic [15:0] rd_cmd_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_TRIG = 2'd2
    } state_t;

    localparam logic [7:0]  LEN_LAST = 8'(WR_LEN - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  byte_cnt;
    logic [7:0]  byte_cnt_nxt;
    logic [19:0] to_cnt;
    logic [19:0] to_cnt_nxt;

    logic        wr_en_nxt;
    logic [7:0]  data_nxt;
    logic        wr_trig_nxt;
    logic        rd_trig_nxt;
    logic        err_nxt;

    logic        hit_rd;
    logic        hit_wr;

    assign hit_rd = rx_flag && (rx_data == RD_CMD);
    assign hit_wr = rx_flag && (rx_data == WR_CMD);

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            byte_cnt    <= 8'd0;
            to_cnt      <= 20'd0;
            wfifo_wr_en <= 1'b0;
            wfifo_data  <= 8'd0;
            wr_trig     <= 1'b0;
            rd_trig     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            wfifo_wr_en <= wr_en_nxt;
            wfifo_data  <= data_nxt;
            wr_trig     <= wr_trig_nxt;
            rd_trig     <= rd_trig_nxt;
            err_timeout <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        to_cnt_nxt   = to_cnt;
        wr_en_nxt    = 1'b0;
        data_nxt     = wfifo_data;
        wr_trig_nxt  = 1'b0;
        rd_trig_nxt  = 1'b0;
        err_nxt      = 1'b0;

        unique case (state)
            // WR_TRIG fires the trigger and decodes a new command byte like IDLE
            IDLE, WR_TRIG: begin
                wr_trig_nxt = (state == WR_TRIG);
                state_nxt   = IDLE;
                unique case (1'b1)
                    hit_rd: rd_trig_nxt = 1'b1;
                    hit_wr: begin
                        state_nxt    = WR_DATA;
                        byte_cnt_nxt = 8'd0;
                        to_cnt_nxt   = 20'd0;
                    end
                    default: ;
                endcase
            end

            WR_DATA: begin
                if (rx_flag) begin
                    wr_en_nxt  = 1'b1;
                    data_nxt   = rx_data;
                    to_cnt_nxt = 20'd0;
                    if (byte_cnt == LEN_LAST) begin
                        state_nxt    = WR_TRIG;
                        byte_cnt_nxt = 8'd0;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 8'd1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_nxt      = 1'b1;
                    state_nxt    = IDLE;
                    byte_cnt_nxt = 8'd0;
                    to_cnt_nxt   = 20'd0;
                end else begin
                    to_cnt_nxt = to_cnt + 20'd1;
                end
            end

            default: begin
                state_nxt    = IDLE;
                byte_cnt_nxt = 8'd0;
                to_cnt_nxt   = 20'd0;
            end
        endcase
    end

`ifdef CMD_DECODE_STAT_EN
    // Event counters follow the registered pulses and stick at all-ones
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            wr_cmd_cnt <= 16'd0;
            rd_cmd_cnt <= 16'd0;
            err_cnt    <= 8'd0;
        end else begin
            if (wr_trig && (wr_cmd_cnt != 16'hFFFF))
                wr_cmd_cnt <= wr_cmd_cnt + 16'd1;
            if (rd_trig && (rd_cmd_cnt != 16'hFFFF))
                rd_cmd_cnt <= rd_cmd_cnt + 16'd1;
            if (err_timeout && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_decode.sv
// Directed bench for sdram_cmd_decode with WR_LEN=4 and TIMEOUT_CYC=100.
module tb_sdram_cmd_decode;

    logic       sclk = 1'b0;
    logic       s_rst_n;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       err_timeout;
`ifdef CMD_DECODE_STAT_EN
    logic [15:0] wr_cmd_cnt;
    logic [15:0] rd_cmd_cnt;
    logic [7:0]  err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    int n_push = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_err  = 0;

    int b_push, b_wr, b_rd, b_err;
    int seen;

    always #5 sclk = ~sclk;

    sdram_cmd_decode #(
        .WR_CMD     (8'h55),
        .RD_CMD     (8'hAA),
        .WR_LEN     (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .rx_data    (rx_data),
        .rx_flag    (rx_flag),
        .wfifo_wr_en(wfifo_wr_en),
        .wfifo_data (wfifo_data),
        .wr_trig    (wr_trig),
        .rd_trig    (rd_trig),
`ifdef CMD_DECODE_STAT_EN
        .wr_cmd_cnt (wr_cmd_cnt),
        .rd_cmd_cnt (rd_cmd_cnt),
        .err_cnt    (err_cnt),
`endif
        .err_timeout(err_timeout)
    );

    // pulse tallies: at each posedge the outputs still show the finished cycle
    always @(posedge sclk) begin
        if (wfifo_wr_en) n_push <= n_push + 1;
        if (wr_trig)     n_wr   <= n_wr + 1;
        if (rd_trig)     n_rd   <= n_rd + 1;
        if (err_timeout) n_err  <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge sclk);
    endtask

    // flag is high for one cycle; returns on the negedge where its response is visible
    task automatic send(input logic [7:0] b);
        @(negedge sclk);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge sclk);
        rx_flag = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic snap();
        b_push = n_push;
        b_wr   = n_wr;
        b_rd   = n_rd;
        b_err  = n_err;
    endtask

    task automatic do_reset();
        @(negedge sclk);
        s_rst_n = 1'b0;
        step(3);
        s_rst_n = 1'b1;
        step(2);
    endtask

    task automatic chk_push(input string tag, input logic [7:0] d);
        chk({tag, "_en"}, 16'(wfifo_wr_en), 16'd1);
        chk({tag, "_data"}, 16'(wfifo_data), 16'(d));
    endtask

    initial begin
        s_rst_n = 1'b0;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        step(3);
        chk("rst_wr_en", 16'(wfifo_wr_en), 16'd0);
        chk("rst_data", 16'(wfifo_data), 16'd0);
        chk("rst_wr_trig", 16'(wr_trig), 16'd0);
        chk("rst_rd_trig", 16'(rd_trig), 16'd0);
        chk("rst_err", 16'(err_timeout), 16'd0);
        s_rst_n = 1'b1;
        step(2);

        // write burst with 20-cycle gaps
        snap();
        send(8'h55);
        chk("wb_cmd_nopush", 16'(wfifo_wr_en), 16'd0);
        step(19); send(8'h11); chk_push("wb_b0", 8'h11);
        step(19); send(8'h22); chk_push("wb_b1", 8'h22);
        step(19); send(8'h33); chk_push("wb_b2", 8'h33);
        chk("wb_no_early_trig", 16'(wr_trig), 16'd0);
        step(19); send(8'h44); chk_push("wb_b3", 8'h44);
        chk("wb_trig_not_with_push", 16'(wr_trig), 16'd0);
        step(1);
        chk("wb_trig", 16'(wr_trig), 16'd1);
        chk("wb_push_done", 16'(wfifo_wr_en), 16'd0);
        step(1);
        chk("wb_trig_width", 16'(wr_trig), 16'd0);
        step(3);
        chk("wb_push_count", 16'(n_push - b_push), 16'd4);
        chk("wb_trig_count", 16'(n_wr - b_wr), 16'd1);
        chk("wb_no_rd", 16'(n_rd - b_rd), 16'd0);

        // single read
        snap();
        send(8'hAA);
        chk("rd_trig", 16'(rd_trig), 16'd1);
        chk("rd_no_push", 16'(wfifo_wr_en), 16'd0);
        step(1);
        chk("rd_width", 16'(rd_trig), 16'd0);
        step(2);
        chk("rd_count", 16'(n_rd - b_rd), 16'd1);
        chk("rd_push_count", 16'(n_push - b_push), 16'd0);

        // ignored byte in IDLE
        snap();
        send(8'h3C);
        step(3);
        chk("idle_ignore", 16'(n_push - b_push + n_rd - b_rd + n_wr - b_wr), 16'd0);

        // payload with command values
        snap();
        send(8'h55);
        send(8'hAA); chk_push("pc_b0", 8'hAA);
        chk("pc_b0_no_rd", 16'(rd_trig), 16'd0);
        send(8'h55); chk_push("pc_b1", 8'h55);
        send(8'hAA); chk_push("pc_b2", 8'hAA);
        send(8'h00); chk_push("pc_b3", 8'h00);
        step(1);
        chk("pc_trig", 16'(wr_trig), 16'd1);
        step(3);
        chk("pc_no_rd", 16'(n_rd - b_rd), 16'd0);
        chk("pc_push_count", 16'(n_push - b_push), 16'd4);

        // timeout after two payload bytes
        snap();
        send(8'h55);
        send(8'h01);
        send(8'h02);
        seen = 0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge sclk);
            if (err_timeout) begin
                seen = k;
                break;
            end
        end
        chk("to_delay", 16'(seen), 16'd100);
        step(1);
        chk("to_width", 16'(err_timeout), 16'd0);
        step(2);
        chk("to_no_wr", 16'(n_wr - b_wr), 16'd0);
        chk("to_err_count", 16'(n_err - b_err), 16'd1);
        send(8'hAA);
        chk("to_then_rd", 16'(rd_trig), 16'd1);

        // byte landing exactly on the terminal count wins
        snap();
        send(8'h55);
        send(8'h01);
        step(98);
        send(8'h02);
        chk_push("race_b1", 8'h02);
        chk("race_no_err", 16'(err_timeout), 16'd0);
        send(8'h03); chk_push("race_b2", 8'h03);
        send(8'h04); chk_push("race_b3", 8'h04);
        step(1);
        chk("race_trig", 16'(wr_trig), 16'd1);
        step(3);
        chk("race_err_count", 16'(n_err - b_err), 16'd0);

        // back-to-back reads
        snap();
        send(8'hAA);
        chk("b2b_rd0", 16'(rd_trig), 16'd1);
        send(8'hAA);
        chk("b2b_rd1", 16'(rd_trig), 16'd1);
        step(2);
        chk("b2b_rd_count", 16'(n_rd - b_rd), 16'd2);

        // reset in the middle of a write
        send(8'h55);
        send(8'h0A);
        send(8'h0B);
        chk_push("mr_b1", 8'h0B);
        s_rst_n = 1'b0;
        step(1);
        chk("mr_wr_en", 16'(wfifo_wr_en), 16'd0);
        chk("mr_data", 16'(wfifo_data), 16'd0);
        chk("mr_wr_trig", 16'(wr_trig), 16'd0);
        chk("mr_rd_trig", 16'(rd_trig), 16'd0);
        chk("mr_err", 16'(err_timeout), 16'd0);
        s_rst_n = 1'b1;
        step(2);
        snap();
        send(8'h0C);
        send(8'h0D);
        step(200);
        chk("mr_no_push", 16'(n_push - b_push), 16'd0);
        chk("mr_no_wr", 16'(n_wr - b_wr), 16'd0);
        chk("mr_no_err", 16'(n_err - b_err), 16'd0);

`ifdef CMD_DECODE_STAT_EN
        do_reset();
        chk("st_rst_wr", wr_cmd_cnt, 16'd0);
        chk("st_rst_rd", rd_cmd_cnt, 16'd0);
        chk("st_rst_err", 16'(err_cnt), 16'd0);
        for (int w = 0; w < 3; w++) begin
            send(8'h55);
            for (int j = 0; j < 4; j++) send(8'(j + 1));
        end
        send(8'hAA);
        send(8'hAA);
        send(8'h55);
        send(8'h07);
        step(110);
        chk("st_wr", wr_cmd_cnt, 16'd3);
        chk("st_rd", rd_cmd_cnt, 16'd2);
        chk("st_err", 16'(err_cnt), 16'd1);
        for (int t = 0; t < 254; t++) begin
            send(8'h55);
            step(102);
        end
        chk("st_err_full", 16'(err_cnt), 16'd255);
        send(8'h55);
        step(105);
        chk("st_err_sat", 16'(err_cnt), 16'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
